// File: rtl/game_ctrl.sv
// Round flow controller for SuperFrog: IDLE/PLAY/DYING/OVER, BCD survival score, sprite restart pulse.
// Optional high-score register is built only when GAME_CTRL_HISCORE_EN is defined.
//   state | meaning
//   IDLE  | power-up, waiting for first start press
//   PLAY  | round running, score accrues per FRAMES_PER_PT frames
//   DYING | falling animation, DIE_FRAMES frames long
//   OVER  | round finished, score shown until restart
module game_ctrl #(
  parameter int DIGITS        = 4,
  parameter int FRAMES_PER_PT = 60,
  parameter int DIE_FRAMES    = 120,
  parameter int TIMW          = 8
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix,
  input  logic                  frame,
  input  logic                  dead,
  input  logic                  btn_start,
  output logic                  run,
  output logic                  game_rst,
  output logic                  game_over,
  output logic [1:0]            state,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hiscore
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [TIMW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [TIMW-1:0]     timer_q, timer_d;
  logic [4*DIGITS-1:0] score_q, score_d, score_inc;
  logic                btn_prev_q;
  logic                run_q, run_d;
  logic                game_rst_q, game_rst_d;
  logic                game_over_q, game_over_d;
  logic                start_edge;
  logic                carry, all_nine;

  assign start_edge = btn_start & ~btn_prev_q;

  // Ripple BCD increment; an all-9s score saturates instead of wrapping.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    all_nine  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (all_nine) score_inc = score_q;
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    timer_d     = timer_q;
    score_d     = score_q;
    game_rst_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d     = PLAY;
          game_rst_d  = 1'b1;
          score_d     = '0;
          frame_cnt_d = '0;
        end
      end
      PLAY: begin
        if (dead) begin
          state_d = DYING;
          timer_d = TIMW'(DIE_FRAMES - 1);
        end else if (frame) begin
          if (frame_cnt_q == TIMW'(FRAMES_PER_PT - 1)) begin
            frame_cnt_d = '0;
            score_d     = score_inc;
          end else begin
            frame_cnt_d = frame_cnt_q + TIMW'(1);
          end
        end
      end
      DYING: begin
        if (frame) begin
          if (timer_q == '0) state_d = OVER;
          else               timer_d = timer_q - TIMW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    run_d       = (state_d == PLAY) || (state_d == DYING);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      timer_q     <= '0;
      score_q     <= '0;
      btn_prev_q  <= 1'b0;
      run_q       <= 1'b0;
      game_rst_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      timer_q     <= timer_d;
      score_q     <= score_d;
      btn_prev_q  <= btn_start;
      run_q       <= run_d;
      game_rst_q  <= game_rst_d;
      game_over_q <= game_over_d;
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [4*DIGITS-1:0] hiscore_q, hiscore_d;
  logic                to_over;

  assign to_over = (state_q == DYING) && frame && (timer_q == '0);

  // Packed BCD digits compare correctly as a plain unsigned vector, MSD first.
  always_comb begin
    hiscore_d = hiscore_q;
    if (to_over && (score_q > hiscore_q)) hiscore_d = score_q;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) hiscore_q <= '0;
    else         hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign state     = state_q;
  assign score     = score_q;
  assign run       = run_q;
  assign game_rst  = game_rst_q;
  assign game_over = game_over_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-flow controller that sits directly downstream of the SuperFrog top-level gameplay logic.
- Consumes the per-frame `frame` strobe and the sticky collision flag `dead`, and runs the round state machine (idle, play, dying, game over).
- Keeps a BCD survival score and an optional high score.
- Drives a one-cycle `game_rst` pulse and a `run` enable back into the sprite-update logic, so a new round restarts sprites without a full system reset.

Parameters:
- DIGITS, 4, number of BCD score digits; score width is 4*DIGITS.
- FRAMES_PER_PT, 60, frames survived per score point; must be >= 1.
- DIE_FRAMES, 120, frames spent in DYING (falling animation) before OVER; must be >= 1.
- TIMW, 8, width of the frame-counter and dying-timer registers; must hold max(FRAMES_PER_PT, DIE_FRAMES).

Ports:
- clk_pix  in  1  pixel clock; all logic is on its rising edge.
- rst_pix  in  1  synchronous active-high reset.
- frame  in  1  one-cycle pulse at start of frame.
- dead  in  1  collision flag; level, sticky until game_rst.
- btn_start  in  1  start button, level, already debounced.
- run  out  1  high in PLAY and DYING; gates sprite/frog motion.
- game_rst  out  1  one-cycle pulse that restarts sprites and clears dead.
- game_over  out  1  high in OVER.
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
- score  out  4*DIGITS  BCD score, digit 0 = LSD.
- hiscore  out  4*DIGITS  BCD high score; tied to 0 when feature is off.

Behaviour:
- All outputs are registered. Reset (rst_pix=1 at an edge) gives: state=IDLE, run=0, game_rst=0, game_over=0, score=0, hiscore=0, frame counter=0, timer=0, btn_prev=0. Reset has priority over every other event; a reset mid-round returns to IDLE in one cycle.
- Start edge: start_edge = btn_start & ~btn_prev, where btn_prev is registered every cycle. Holding the button produces exactly one edge.
- IDLE:
  - run=0.
  - On start_edge: next cycle game_rst=1, score=0, frame counter=0, state=PLAY.
- PLAY:
  - run=1.
  - If dead=1, in any cycle: next state is DYING and timer is loaded with DIE_FRAMES-1. No score update occurs that cycle, even if frame=1.
  - Else on frame=1: if frame counter == FRAMES_PER_PT-1, the counter wraps to 0 and score increments by one; otherwise the counter increments.
  - BCD increment: a digit at 9 becomes 0 and carries into the next digit. If every digit is 9, the score saturates and holds all 9s.
  - start_edge is ignored.
- DYING:
  - run=1.
  - On frame=1: if timer==0, go to OVER; else decrement timer.
  - start_edge is ignored.
- OVER:
  - run=0, game_over=1.
  - On start_edge: game_rst pulse, score cleared, counter cleared, state=PLAY.
  - The score remains visible until restart.
- game_rst:
  - Exactly one cycle wide.
  - Asserted in the same cycle the state register first reads PLAY.
  - Never asserted by rst_pix itself.
- The state output equals the state register with no extra delay.
- Latency: from start_edge to game_rst=1 is one cycle. From dead rising to state=DYING is one cycle. Total DYING duration is exactly DIE_FRAMES frame pulses.

Optional Feature:
- Macro: GAME_CTRL_HISCORE_EN.
- Defined: on the DYING->OVER transition, if score > hiscore (BCD compare, MSD first), then hiscore <= score in that same cycle. hiscore survives game_rst and is cleared only by rst_pix.
- Not defined: no hiscore register or comparator is built, and hiscore is constant 0.

Test Plan:
- Reset then idle: rst_pix for 2 cycles, btn_start=0 for 1000 cycles -> state=0, run=0, game_rst never asserted, score=0.
- Scoring (FRAMES_PER_PT=2, DIGITS=2): start, then 25 frame pulses with dead=0 -> score=0x12. Continue to 198 total frames -> score=0x99, and further frames hold it at 0x99.
- Death (DIE_FRAMES=3): in PLAY, dead=1 coincident with frame -> score unchanged, state=2 next cycle. State stays 2 through 2 more frames and becomes 3 on the 3rd frame, with game_over=1 and run=0.
- Restart: in OVER, hold btn_start=1 for 50 cycles -> exactly one game_rst pulse, state=1, score=0. Pressing start during PLAY or DYING -> no effect.
- Hiscore (macro defined): first round ends with score 0x07, second with 0x03 -> hiscore=0x07. Third round ends with 0x11 -> hiscore=0x11. With the macro undefined, hiscore stays 0 throughout.
- Reset mid-DYING: rst_pix asserted while state=2 -> next cycle state=0, score=0, hiscore=0, run=0.
